// File: rtl/uopc_pkg.sv
// Shared types and sizing for the uop loop controller.
// No logic; FSM state encoding and default cache geometry only.
// Imported by uop_loop_ctrl and uopc_skid_fifo.
package uopc_pkg;

    localparam int UOPC_DEPTH = 64;
    localparam int UOPC_AW    = 6;
    localparam int UOPC_DW    = 32;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        REPLAY,
        DRAIN
    } uopc_state_t;

endpackage

// File: rtl/uopc_skid_fifo.sv
// 2-entry skid FIFO catching cache read data behind the output handshake.
// Latency: push visible at head the next cycle; occ updates on the same edge.
// Backpressure: none internally; the caller never pushes into a full FIFO.
module uopc_skid_fifo
    import uopc_pkg::*;
#(
    parameter int DW = UOPC_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] head_dat,
    output logic [1:0]    occ
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (clr) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/uop_loop_ctrl.sv
// Captures a decoded-uop loop body into the uop cache, then replays it loop_count times.
// Latency: first replayed uop 2 cycles after REPLAY entry, then 1 uop/cycle. Optional UOPC_PERF_EN adds perf_replayed.
// Backpressure: in_ready only in FILL; out_ready stalls reads so the 2-entry skid FIFO never overflows.
module uop_loop_ctrl
    import uopc_pkg::*;
#(
    parameter int DEPTH = UOPC_DEPTH,
    parameter int AW    = UOPC_AW,
    parameter int DW    = UOPC_DW,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] loop_count,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_instr,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_instr,
    output logic          cache_we,
    output logic [AW-1:0] cache_waddr,
    output logic [DW-1:0] cache_wdata,
    output logic          cache_re,
    output logic [AW-1:0] cache_raddr,
    input  logic [DW-1:0] cache_rdata,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   body_len
`ifdef UOPC_PERF_EN
    ,
    output logic [31:0]   perf_replayed
`endif
);

    uopc_state_t   state;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] pass_cnt;
    logic          inflight;
    logic [1:0]    occ;
    logic          in_hs;
    logic          fill_end;
    logic          pop;
    logic          rd_wrap;

    assign in_hs    = in_valid & in_ready;
    assign fill_end = in_hs & (in_last | (wptr == AW'(DEPTH - 1)));
    assign pop      = out_valid & out_ready;
    assign rd_wrap  = ({1'b0, rptr} == (body_len - 1'b1));

    assign cache_we    = in_hs;
    assign cache_waddr = wptr;
    assign cache_wdata = in_ready ? in_instr : '0;
    assign cache_raddr = rptr;
    // occ + inflight - pop < 2, rearranged to stay unsigned
    assign cache_re    = (state == REPLAY) &&
                         (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    assign out_valid = (occ != 2'd0);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wptr     <= '0;
            rptr     <= '0;
            pass_cnt <= '0;
            inflight <= 1'b0;
            in_ready <= 1'b0;
            done     <= 1'b0;
            body_len <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= cache_re;
            if (flush) begin
                state    <= IDLE;
                in_ready <= 1'b0;
                inflight <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= FILL;
                            in_ready <= 1'b1;
                            wptr     <= '0;
                            rptr     <= '0;
                            pass_cnt <= (loop_count == '0) ? CW'(1) : loop_count;
                        end
                    end
                    FILL: begin
                        if (in_hs) begin
                            wptr <= wptr + 1'b1;
                            if (fill_end) begin
                                body_len <= {1'b0, wptr} + 1'b1;
                                in_ready <= 1'b0;
                                state    <= REPLAY;
                            end
                        end
                    end
                    REPLAY: begin
                        if (cache_re) begin
                            if (rd_wrap) begin
                                rptr     <= '0;
                                pass_cnt <= pass_cnt - 1'b1;
                                if (pass_cnt == CW'(1)) begin
                                    state <= DRAIN;
                                end
                            end else begin
                                rptr <= rptr + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if ((occ == 2'd0) && !inflight) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    uopc_skid_fifo #(.DW(DW)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .clr      (flush),
        .push     (inflight),
        .push_dat (cache_rdata),
        .pop      (pop),
        .head_dat (out_instr),
        .occ      (occ)
    );

`ifdef UOPC_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_replayed <= '0;
        end else if ((state == IDLE) && start && !flush) begin
            perf_replayed <= '0;
        end else if (pop && (perf_replayed != 32'hFFFF_FFFF)) begin
            perf_replayed <= perf_replayed + 32'd1;
        end
    end
`endif

endmodule
